// File: rtl/hex_display_ctrl_if.sv
// rtl/hex_display_ctrl_if.sv - load/result bus between a host and the hex display controller
interface hex_display_ctrl_if #(
    parameter int NUM_DIGITS = 6,
    parameter int VALUE_W    = 20
);
    logic [VALUE_W-1:0]      value;
    logic                    load;
    logic                    busy;
    logic                    done;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_en;

    modport master (
        output value, load,
        input  busy, done, digits, digit_en
    );

    modport slave (
        input  value, load,
        output busy, done, digits, digit_en
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - serial double-dabble binary-to-BCD converter with leading-zero mask
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int VALUE_W    = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    hex_display_ctrl_if.slave  bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

    function automatic logic [63:0] max_val(input int nd);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < nd; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    // Largest value that fits in NUM_DIGITS decimal digits.
    localparam logic [63:0] MAXVAL = max_val(NUM_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t              state_q;
    logic [VALUE_W-1:0]  shift_q;
    logic [VALUE_W-1:0]  shift_d;
    logic [BCD_W-1:0]    bcd_q;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;
    logic                busy_q;
    logic                done_q;
    logic [BCD_W-1:0]    digits_q;
    logic [NUM_DIGITS-1:0] en_q;
    logic [NUM_DIGITS-1:0] en_d;
    logic                seen_nz;
    logic                ovf_d;

    assign ovf_d = ({{(64-VALUE_W){1'b0}}, bus.value} > MAXVAL);

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[VALUE_W-1]};
        shift_d = shift_q << 1;

        // A digit is significant once any digit at or above it is nonzero.
        seen_nz = 1'b0;
        en_d    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen_nz = seen_nz | (bcd_d[4*i +: 4] != 4'd0);
            en_d[i] = seen_nz;
        end
        en_d[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= '0;
            en_q     <= {{(NUM_DIGITS-1){1'b0}}, 1'b1};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.load) begin
                        shift_q <= bus.value;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_W'(VALUE_W - 1);
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b1;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd_q   <= bcd_d;
                    shift_q <= shift_d;
                    if (cnt_q == '0) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        digits_q <= ovf_q ? {NUM_DIGITS{4'hA}} : bcd_d;
                        en_q     <= ovf_q ? {NUM_DIGITS{1'b1}} : en_d;
                        state_q  <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.digits   = digits_q;
    assign bus.digit_en = en_q;
endmodule
